// File: rtl/ups_da_slew.sv
// Per-channel setpoint slew limiter and strobe pacer that feeds the dual-channel DAC SPI writer.
// Optional build macro UPS_DA_SLEW_CLAMP_EN clamps written targets to MAX_CODE.
module ups_da_slew #(
    parameter int unsigned UPDATE_PERIOD = 256,
    parameter int unsigned STEP          = 16,
    parameter logic [11:0] MAX_CODE      = 12'hE66
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tgt_wr,
    input  logic        tgt_ch,
    input  logic [11:0] tgt_data,
    output logic        dv0,
    output logic [11:0] data0,
    output logic        dv1,
    output logic [11:0] data1,
    output logic        at_tgt0,
    output logic        at_tgt1
);

    localparam int unsigned CW = $clog2(UPDATE_PERIOD);
    localparam logic [CW-1:0] CNT_LAST = CW'(UPDATE_PERIOD - 1);
    localparam logic [12:0] STEP13 = 13'(STEP);

    localparam logic [1:0] S_WAIT  = 2'd0;
    localparam logic [1:0] S_ARB   = 2'd1;
    localparam logic [1:0] S_ISSUE = 2'd2;

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0]       state_q, state_d;
    logic             turn_q;
    logic [1:0][11:0] cur_q, tgt_q;
    logic [1:0]       pend_q;
    logic             dv0_q, dv1_q;
    logic [11:0]      data0_q, data1_q;

    logic             tick;
    logic             sel, have;
    logic [12:0]      cur_s, tgt_s, diff;
    logic [12:0]      nxt13;
    logic [11:0]      nxt;
    logic [11:0]      wr_code;

`ifdef UPS_DA_SLEW_CLAMP_EN
    assign wr_code = (tgt_data > MAX_CODE) ? MAX_CODE : tgt_data;
`else
    logic unused_max_code;
    assign unused_max_code = ^MAX_CODE;
    assign wr_code = tgt_data;
`endif

    assign tick  = (cnt_q == CNT_LAST);
    assign cnt_d = tick ? '0 : cnt_q + CW'(1);

    // Round-robin pick: the channel not served last goes first when both are pending.
    always_comb begin
        sel  = turn_q;
        have = 1'b0;
        if (pend_q[turn_q]) begin
            sel  = turn_q;
            have = 1'b1;
        end else if (pend_q[~turn_q]) begin
            sel  = ~turn_q;
            have = 1'b1;
        end
        cur_s = {1'b0, cur_q[sel]};
        tgt_s = {1'b0, tgt_q[sel]};
        if (tgt_s >= cur_s) begin
            diff  = tgt_s - cur_s;
            nxt13 = (diff <= STEP13) ? tgt_s : cur_s + STEP13;
        end else begin
            diff  = cur_s - tgt_s;
            nxt13 = (diff <= STEP13) ? tgt_s : cur_s - STEP13;
        end
        nxt = nxt13[11:0];
    end

    always_comb begin
        state_d = S_WAIT;
        case (state_q)
            S_WAIT:  state_d = tick ? S_ARB : S_WAIT;
            S_ARB:   state_d = have ? S_ISSUE : S_WAIT;
            S_ISSUE: state_d = S_WAIT;
            default: state_d = S_WAIT;
        endcase
    end

    // The step is committed on the ARB->ISSUE edge so the strobe is visible
    // during ISSUE, two clocks after the tick.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            state_q <= S_WAIT;
            turn_q  <= 1'b0;
            cur_q   <= '0;
            tgt_q   <= '0;
            pend_q  <= '0;
            dv0_q   <= 1'b0;
            dv1_q   <= 1'b0;
            data0_q <= '0;
            data1_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
            dv0_q   <= 1'b0;
            dv1_q   <= 1'b0;
            if (state_q == S_ARB && have) begin
                cur_q[sel] <= nxt;
                turn_q     <= ~sel;
                if (nxt == tgt_q[sel]) pend_q[sel] <= 1'b0;
                if (sel) begin
                    dv1_q   <= 1'b1;
                    data1_q <= nxt;
                end else begin
                    dv0_q   <= 1'b1;
                    data0_q <= nxt;
                end
            end
            // A concurrent host write outranks the pending clear above.
            if (tgt_wr) begin
                tgt_q[tgt_ch]  <= wr_code;
                pend_q[tgt_ch] <= 1'b1;
            end
        end
    end

    assign dv0     = dv0_q;
    assign dv1     = dv1_q;
    assign data0   = data0_q;
    assign data1   = data1_q;
    assign at_tgt0 = (cur_q[0] == tgt_q[0]) & ~pend_q[0];
    assign at_tgt1 = (cur_q[1] == tgt_q[1]) & ~pend_q[1];

endmodule

// File: doc/ups_da_slew.md
Name: ups_da_slew

Overview:
- Setpoint slew-rate limiter and update pacer that sits directly upstream of the dual-channel DAC SPI writer.
- Host/control logic writes 12-bit target codes per channel. The block steps each channel's output code toward its target by at most STEP per update.
- Each step is issued as a one-cycle dv0/data0 or dv1/data1 strobe.
- Strobes are spaced so the DAC writer always finishes its SPI/LDAC transaction before the next strobe arrives.

Parameters:
UPDATE_PERIOD, 256, clk cycles between update opportunities; must be >= 200 (exceeds one full DAC write incl. CS/LDAC).
STEP, 16, max code change per update; legal range 1..4095.
MAX_CODE, 12'hE66, upper code limit, used only when UPS_DA_SLEW_CLAMP_EN is defined.

Ports:
clk  in  1  system clock
rst_n  in  1  reset; synchronous, active-low
tgt_wr  in  1  one-cycle target write strobe
tgt_ch  in  1  target channel select (0/1)
tgt_data  in  12  target code
dv0  out  1  one-cycle update strobe, channel 0
data0  out  12  channel-0 code, valid while dv0=1, held afterwards
dv1  out  1  one-cycle update strobe, channel 1
data1  out  12  channel-1 code, valid while dv1=1, held afterwards
at_tgt0  out  1  channel 0: cur0==tgt0 and no pending refresh
at_tgt1  out  1  channel 1: cur1==tgt1 and no pending refresh

Behaviour:
- Reset values: cur0/1=0, tgt0/1=0, pend0/1=0, dv0/1=0, data0/1=0, period counter=0, turn=0, state=WAIT, at_tgt0/1=1.
- Reset asserted mid-ramp aborts everything. Outputs take reset values the next clk; no dv is produced during reset.
- Period counter: free-running 0..UPDATE_PERIOD-1, wraps to 0. tick=1 when counter==UPDATE_PERIOD-1. Counter never stalls, so dv strobes are spaced by multiples of UPDATE_PERIOD.
- Target write: on tgt_wr, tgt[tgt_ch]<=tgt_data and pend[tgt_ch]<=1. A write equal to cur still forces one refresh strobe. A later write overrides an earlier one; no queueing.
- FSM:
  - WAIT: on tick -> ARB.
  - ARB: sel = turn if pend[turn], else ~turn if pend[~turn], else none.
    - If none: -> WAIT, turn unchanged.
    - Else compute nxt = tgt if |tgt-cur|<=STEP, else cur±STEP toward tgt. Use 13-bit arithmetic; no wrap past 0 or 4095. Then -> ISSUE.
  - ISSUE: dv[sel]<=1 and data[sel]<=nxt for exactly one cycle; cur[sel]<=nxt; pend[sel] cleared if nxt==tgt[sel]; turn<=~sel; -> WAIT.
- Latency: dv asserts 2 clks after the tick cycle (tick -> ARB -> ISSUE -> dv visible).
- Channels alternate when both are pending. dv0 and dv1 are never asserted in the same cycle.
- tgt_wr in the same cycle as ARB for the same channel: ARB uses the old tgt, the new tgt is stored, and pend remains 1. The register update wins over the ISSUE clear of pend.
- at_tgtN is combinational from registered state: (curN==tgtN) & ~pendN.

Optional Feature:
UPS_DA_SLEW_CLAMP_EN
- Defined: tgt_data > MAX_CODE is stored as MAX_CODE at write time, so data0/1 never exceed MAX_CODE.
- Undefined: tgt_data is stored unchanged, full 0..4095 range, and MAX_CODE is unused.

Test Plan:
1. After reset, write ch0 tgt=0x040 -> dv0 strobes with data0=0x010,0x020,0x030,0x040, each 256 clks apart; no further dv0; at_tgt0 rises after the last strobe.
2. With cur0=0x040, write ch0 tgt=0x038 -> single dv0 with data0=0x038 (partial step).
3. In the same period, write ch0=0x020 and ch1=0x020 -> sequence dv0 0x010, dv1 0x010, dv0 0x020, dv1 0x020, each 256 clks apart, never coincident.
4. With cur1=0x100, write ch1 tgt=0x100 -> exactly one dv1 with data1=0x100; at_tgt1 low until that strobe.
5. Assert rst_n=0 for 1 clk mid-ramp (cur0=0x020, tgt0=0x080) -> dv0/1=0 and data0/1=0 next clk; no strobes afterwards until a new tgt_wr.
6. Write ch0 tgt=0xFFF, STEP=4095 -> with UPS_DA_SLEW_CLAMP_EN, single dv0 with data0=0xE66; without it, data0=0xFFF.
